// File: rtl/retire_unit.sv
// Two-stage commit retirement: S1 frees old physical mappings and looks up the arch index,
// S2 drives the architectural register-file writes. Optional counter: RETIRE_PERF_CNT_EN.
module retire_unit #(
    parameter int PHYS_W = 6,
    parameter int ARCH_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              retire_hold,
    input  logic              commit_valid_1,
    input  logic              commit_valid_2,
    input  logic [PHYS_W-1:0] commit_dest_1,
    input  logic [PHYS_W-1:0] commit_dest_2,
    input  logic [PHYS_W-1:0] free_oldDest_1,
    input  logic [PHYS_W-1:0] free_oldDest_2,
    input  logic [DATA_W-1:0] commit_value_1,
    input  logic [DATA_W-1:0] commit_value_2,
    output logic              commit_ready,
    output logic              retire_valid1,
    output logic              retire_valid2,
    output logic [PHYS_W-1:0] retire_phys_reg1,
    output logic [PHYS_W-1:0] retire_phys_reg2,
    output logic [PHYS_W-1:0] retire_cur_phys_reg1,
    output logic [PHYS_W-1:0] retire_cur_phys_reg2,
    input  logic [ARCH_W-1:0] arch_reg1,
    input  logic [ARCH_W-1:0] arch_reg2,
    output logic              RegWrite1,
    output logic              RegWrite2,
    output logic [ARCH_W-1:0] rd1,
    output logic [ARCH_W-1:0] rd2,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              proto_err,
    output logic [31:0]       retired_count
);

    logic              w_take1;
    logic              w_take2;
    logic              w_proto;

    logic              r_s1_valid1;
    logic              r_s1_valid2;
    logic [PHYS_W-1:0] r_s1_dest1;
    logic [PHYS_W-1:0] r_s1_dest2;
    logic [PHYS_W-1:0] r_s1_old1;
    logic [PHYS_W-1:0] r_s1_old2;
    logic [DATA_W-1:0] r_s1_value1;
    logic [DATA_W-1:0] r_s1_value2;

    logic              r_s2_valid1;
    logic              r_s2_valid2;
    logic [ARCH_W-1:0] r_s2_rd1;
    logic [ARCH_W-1:0] r_s2_rd2;
    logic [DATA_W-1:0] r_s2_data1;
    logic [DATA_W-1:0] r_s2_data2;

    logic              r_proto_err;

    // Ready is forced low during reset so the ROB never retires into a flushed pipe.
    assign commit_ready = reset_n & ~retire_hold;

    // A lone slot-2 commit breaks in-order retirement; the whole group is dropped.
    assign w_proto = commit_valid_2 & ~commit_valid_1;
    assign w_take1 = commit_ready & commit_valid_1;
    assign w_take2 = commit_ready & commit_valid_1 & commit_valid_2;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid1 <= 1'b0;
            r_s1_valid2 <= 1'b0;
            r_s1_dest1  <= '0;
            r_s1_dest2  <= '0;
            r_s1_old1   <= '0;
            r_s1_old2   <= '0;
            r_s1_value1 <= '0;
            r_s1_value2 <= '0;
        end else begin
            r_s1_valid1 <= w_take1;
            r_s1_valid2 <= w_take2;
            if (w_take1) begin
                r_s1_dest1  <= commit_dest_1;
                r_s1_old1   <= free_oldDest_1;
                r_s1_value1 <= commit_value_1;
            end
            if (w_take2) begin
                r_s1_dest2  <= commit_dest_2;
                r_s1_old2   <= free_oldDest_2;
                r_s1_value2 <= commit_value_2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_proto_err <= 1'b0;
        end else if (commit_ready && w_proto) begin
            r_proto_err <= 1'b1;
        end
    end

    // S2 samples unconditionally; arch_reg is the rename answer to this cycle's S1 key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid1 <= 1'b0;
            r_s2_valid2 <= 1'b0;
            r_s2_rd1    <= '0;
            r_s2_rd2    <= '0;
            r_s2_data1  <= '0;
            r_s2_data2  <= '0;
        end else begin
            r_s2_valid1 <= r_s1_valid1;
            r_s2_valid2 <= r_s1_valid2;
            r_s2_rd1    <= arch_reg1;
            r_s2_rd2    <= arch_reg2;
            r_s2_data1  <= r_s1_value1;
            r_s2_data2  <= r_s1_value2;
        end
    end

    // Physical register 0 is the permanent x0 mapping and is never returned.
    assign retire_valid1        = r_s1_valid1 & (r_s1_old1 != '0);
    assign retire_valid2        = r_s1_valid2 & (r_s1_old2 != '0);
    assign retire_phys_reg1     = r_s1_old1;
    assign retire_phys_reg2     = r_s1_old2;
    assign retire_cur_phys_reg1 = r_s1_dest1;
    assign retire_cur_phys_reg2 = r_s1_dest2;

    assign rd1      = r_s2_rd1;
    assign rd2      = r_s2_rd2;
    assign rd1_data = r_s2_data1;
    assign rd2_data = r_s2_data2;

    // NOTE: combinational outputs get defaults first so no path can infer a latch.
    always_comb begin
        RegWrite1 = 1'b0;
        RegWrite2 = 1'b0;
        if (r_s2_valid1 && (r_s2_rd1 != '0)) begin
            RegWrite1 = 1'b1;
        end
        if (r_s2_valid2 && (r_s2_rd2 != '0)) begin
            RegWrite2 = 1'b1;
        end
        // Younger slot 2 wins a same-index write.
        if (r_s2_valid1 && r_s2_valid2 && (r_s2_rd1 == r_s2_rd2)) begin
            RegWrite1 = 1'b0;
        end
    end

    assign proto_err = r_proto_err;

`ifdef RETIRE_PERF_CNT_EN
    logic [31:0] r_retired_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired_count <= '0;
        end else begin
            r_retired_count <= r_retired_count + 32'(w_take1) + 32'(w_take2);
        end
    end

    assign retired_count = r_retired_count;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Directed self-checking bench for retire_unit; rename lookup is driven by hand per step.
module tb_retire_unit;

    localparam int PHYS_W = 6;
    localparam int ARCH_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              retire_hold;
    logic              commit_valid_1, commit_valid_2;
    logic [PHYS_W-1:0] commit_dest_1, commit_dest_2;
    logic [PHYS_W-1:0] free_oldDest_1, free_oldDest_2;
    logic [DATA_W-1:0] commit_value_1, commit_value_2;
    logic              commit_ready;
    logic              retire_valid1, retire_valid2;
    logic [PHYS_W-1:0] retire_phys_reg1, retire_phys_reg2;
    logic [PHYS_W-1:0] retire_cur_phys_reg1, retire_cur_phys_reg2;
    logic [ARCH_W-1:0] arch_reg1, arch_reg2;
    logic              RegWrite1, RegWrite2;
    logic [ARCH_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] rd1_data, rd2_data;
    logic              proto_err;
    logic [31:0]       retired_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 0;

    retire_unit #(.PHYS_W(PHYS_W), .ARCH_W(ARCH_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .retire_hold(retire_hold),
        .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
        .commit_dest_1(commit_dest_1), .commit_dest_2(commit_dest_2),
        .free_oldDest_1(free_oldDest_1), .free_oldDest_2(free_oldDest_2),
        .commit_value_1(commit_value_1), .commit_value_2(commit_value_2),
        .commit_ready(commit_ready),
        .retire_valid1(retire_valid1), .retire_valid2(retire_valid2),
        .retire_phys_reg1(retire_phys_reg1), .retire_phys_reg2(retire_phys_reg2),
        .retire_cur_phys_reg1(retire_cur_phys_reg1), .retire_cur_phys_reg2(retire_cur_phys_reg2),
        .arch_reg1(arch_reg1), .arch_reg2(arch_reg2),
        .RegWrite1(RegWrite1), .RegWrite2(RegWrite2),
        .rd1(rd1), .rd2(rd2), .rd1_data(rd1_data), .rd2_data(rd2_data),
        .proto_err(proto_err), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
`ifdef RETIRE_PERF_CNT_EN
        check(tag, 64'(retired_count), 64'(exp_cnt));
`else
        check(tag, 64'(retired_count), 64'd0);
`endif
    endtask

    initial begin
        reset_n = 1'b0; retire_hold = 1'b0;
        commit_valid_1 = 1'b0; commit_valid_2 = 1'b0;
        commit_dest_1 = '0; commit_dest_2 = '0;
        free_oldDest_1 = '0; free_oldDest_2 = '0;
        commit_value_1 = '0; commit_value_2 = '0;
        arch_reg1 = '0; arch_reg2 = '0;

        // Reset state
        #12;
        check("rst_ready", 64'(commit_ready), 64'd0);
        check("rst_rv1", 64'(retire_valid1), 64'd0);
        check("rst_rw1", 64'(RegWrite1), 64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        check("rst_phys1", 64'(retire_phys_reg1), 64'd0);
        check("rst_rd1data", 64'(rd1_data), 64'd0);
        check_count("rst_cnt");
        reset_n = 1'b1;
        step();

        // Single commit
        commit_valid_1 = 1'b1; commit_dest_1 = 6'd32; free_oldDest_1 = 6'd1;
        commit_value_1 = 32'hDEADBEEF;
        #1 check("single_ready", 64'(commit_ready), 64'd1);
        step(); exp_cnt += 1;
        check("single_rv1", 64'(retire_valid1), 64'd1);
        check("single_rv2", 64'(retire_valid2), 64'd0);
        check("single_phys1", 64'(retire_phys_reg1), 64'd1);
        check("single_cur1", 64'(retire_cur_phys_reg1), 64'd32);
        commit_valid_1 = 1'b0; arch_reg1 = 5'd1;
        step();
        check("single_rw1", 64'(RegWrite1), 64'd1);
        check("single_rw2", 64'(RegWrite2), 64'd0);
        check("single_rd1", 64'(rd1), 64'd1);
        check("single_data1", 64'(rd1_data), 64'hDEADBEEF);
        check("single_rv1_drain", 64'(retire_valid1), 64'd0);
        check_count("single_cnt");

        // Dual commit followed back-to-back by a same-index group
        commit_valid_1 = 1'b1; commit_valid_2 = 1'b1;
        commit_dest_1 = 6'd32; commit_dest_2 = 6'd33;
        free_oldDest_1 = 6'd2; free_oldDest_2 = 6'd3;
        commit_value_1 = 32'hA1; commit_value_2 = 32'hB2;
        step(); exp_cnt += 2;
        check("dual_rv1", 64'(retire_valid1), 64'd1);
        check("dual_rv2", 64'(retire_valid2), 64'd1);
        check("dual_phys2", 64'(retire_phys_reg2), 64'd3);
        check("dual_cur2", 64'(retire_cur_phys_reg2), 64'd33);
        check_count("dual_cnt");
        arch_reg1 = 5'd2; arch_reg2 = 5'd3;
        commit_dest_1 = 6'd40; commit_dest_2 = 6'd41;
        free_oldDest_1 = 6'd8; free_oldDest_2 = 6'd9;
        commit_value_1 = 32'h11; commit_value_2 = 32'h22;
        step(); exp_cnt += 2;
        check("dual_rw1", 64'(RegWrite1), 64'd1);
        check("dual_rw2", 64'(RegWrite2), 64'd1);
        check("dual_rd1", 64'(rd1), 64'd2);
        check("dual_rd2", 64'(rd2), 64'd3);
        check("dual_data1", 64'(rd1_data), 64'hA1);
        check("dual_data2", 64'(rd2_data), 64'hB2);
        check("b2b_rv1", 64'(retire_valid1), 64'd1);
        check("b2b_phys1", 64'(retire_phys_reg1), 64'd8);
        commit_valid_1 = 1'b0; commit_valid_2 = 1'b0;
        arch_reg1 = 5'd5; arch_reg2 = 5'd5;
        step();
        check("same_rw1", 64'(RegWrite1), 64'd0);
        check("same_rw2", 64'(RegWrite2), 64'd1);
        check("same_rd2", 64'(rd2), 64'd5);
        check("same_data2", 64'(rd2_data), 64'h22);
        check_count("same_cnt");

        // x0 cases: oldDest 0 is not freed, arch 0 is not written, but it still counts
        commit_valid_1 = 1'b1; commit_dest_1 = 6'd34; free_oldDest_1 = 6'd0;
        commit_value_1 = 32'h7;
        step(); exp_cnt += 1;
        check("x0_rv1", 64'(retire_valid1), 64'd0);
        check("x0_cur1", 64'(retire_cur_phys_reg1), 64'd34);
        commit_valid_1 = 1'b0; arch_reg1 = 5'd0; arch_reg2 = 5'd0;
        step();
        check("x0_rw1", 64'(RegWrite1), 64'd0);
        check("x0_rw2", 64'(RegWrite2), 64'd0);
        check_count("x0_cnt");

        // Hold for 3 cycles with a valid commit waiting
        step();
        retire_hold = 1'b1;
        commit_valid_1 = 1'b1; commit_dest_1 = 6'd42; free_oldDest_1 = 6'd4;
        commit_value_1 = 32'h1234; arch_reg1 = 5'd6;
        #1 check("hold_ready", 64'(commit_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rv1", 64'(retire_valid1), 64'd0);
            check("hold_rw1", 64'(RegWrite1), 64'd0);
        end
        check_count("hold_cnt");
        retire_hold = 1'b0;
        #1 check("release_ready", 64'(commit_ready), 64'd1);
        step(); exp_cnt += 1;
        check("release_rv1", 64'(retire_valid1), 64'd1);
        check("release_phys1", 64'(retire_phys_reg1), 64'd4);
        commit_valid_1 = 1'b0;
        step();
        check("release_rw1", 64'(RegWrite1), 64'd1);
        check("release_rd1", 64'(rd1), 64'd6);
        check("release_data1", 64'(rd1_data), 64'h1234);

        // Protocol error: slot 2 without slot 1
        commit_valid_2 = 1'b1; commit_dest_2 = 6'd35; free_oldDest_2 = 6'd5;
        arch_reg2 = 5'd7;
        step();
        check("proto_rv1", 64'(retire_valid1), 64'd0);
        check("proto_rv2", 64'(retire_valid2), 64'd0);
        check("proto_err_set", 64'(proto_err), 64'd1);
        commit_valid_2 = 1'b0;
        step();
        check("proto_rw1", 64'(RegWrite1), 64'd0);
        check("proto_rw2", 64'(RegWrite2), 64'd0);
        step();
        check("proto_sticky", 64'(proto_err), 64'd1);
        check_count("proto_cnt");

        // Reset in the middle of traffic
        commit_valid_1 = 1'b1; commit_dest_1 = 6'd36; free_oldDest_1 = 6'd6;
        commit_value_1 = 32'h55;
        step(); exp_cnt += 1;
        arch_reg1 = 5'd3; free_oldDest_1 = 6'd7;
        step(); exp_cnt += 1;
        check("mid_rw1", 64'(RegWrite1), 64'd1);
        check("mid_rv1", 64'(retire_valid1), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ready", 64'(commit_ready), 64'd0);
        check("midrst_rv1", 64'(retire_valid1), 64'd0);
        check("midrst_phys1", 64'(retire_phys_reg1), 64'd0);
        check("midrst_cur1", 64'(retire_cur_phys_reg1), 64'd0);
        check("midrst_rw1", 64'(RegWrite1), 64'd0);
        check("midrst_rd1", 64'(rd1), 64'd0);
        check("midrst_data1", 64'(rd1_data), 64'd0);
        check("midrst_proto", 64'(proto_err), 64'd0);
        exp_cnt = 0;
        check_count("midrst_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
